// File: rtl/systolic_array_is_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_is_ctrl
// Tile sequencer for the input-stationary systolic array. One tile at a time:
// preload ARRAY_WIDTH stationary input vectors, stream num_vec weight vectors,
// then drain the pipeline while tagging each valid psum vector with its
// writeback address. A valid-bit shift register tracks which array output
// cycles carry real results; writeback backpressure freezes the whole pipe.
//
// Optional build macro: SA_CTRL_PERF_EN adds stall_cnt / busy_cnt outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module systolic_array_is_ctrl #(
  parameter int ARRAY_HEIGHT = 16,
  parameter int ARRAY_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int CNT_WIDTH    = 10,
  parameter int OUT_LATENCY  = ARRAY_WIDTH + ARRAY_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  ready,
  output logic                  done,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_rd_addr,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  input_en,
  output logic                  process_en,
  input  logic                  psum_ready,
  output logic                  psum_valid,
  output logic [ADDR_WIDTH-1:0] psum_wr_addr
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           busy_cnt
`endif
);

  localparam int LCW = $clog2(ARRAY_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   num_vec_q, num_vec_d;
  logic [ADDR_WIDTH-1:0]  in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0]  w_base_q, w_base_d;
  logic [ADDR_WIDTH-1:0]  out_base_q, out_base_d;
  logic [LCW-1:0]         load_cnt_q, load_cnt_d;   // input vectors issued
  logic [CNT_WIDTH-1:0]   k_q, k_d;                 // weight vectors issued
  logic [CNT_WIDTH-1:0]   j_q, j_d;                 // psum vectors written
  logic                   pend_q, pend_d;           // weight read data waiting at weight_in
  logic [OUT_LATENCY-1:0] vld_q, vld_d;             // marks real results in flight
  logic                   input_en_q;

  logic accept;   // start taken this cycle
  logic stall;    // valid psum refused by writeback: freeze the pipe
  logic emit;     // psum vector handed to writeback

  assign ready        = (state_q == S_IDLE);
  assign done         = (state_q == S_FIN);
  assign input_en     = input_en_q;
  assign psum_valid   = vld_q[OUT_LATENCY-1];
  assign in_rd_addr   = in_base_q + ADDR_WIDTH'(load_cnt_q);
  // Address only moves on an issue, so it stays put through the drain.
  assign w_rd_addr    = w_base_q + ADDR_WIDTH'(k_q);
  assign psum_wr_addr = out_base_q + ADDR_WIDTH'(j_q);

  assign accept = ready && start;
  assign stall  = psum_valid && !psum_ready;
  assign emit   = psum_valid && psum_ready;

  // Next-state, counters and array/SRAM control strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    in_base_d  = in_base_q;
    w_base_d   = w_base_q;
    out_base_d = out_base_q;
    load_cnt_d = load_cnt_q;
    k_d        = k_q;
    j_d        = j_q;
    vld_d      = vld_q;
    in_rd_en   = 1'b0;
    w_rd_en    = 1'b0;

    // Weight data is consumed whenever one is pending; in drain the array
    // keeps advancing on don't-care weights. A stall freezes both.
    process_en = !stall && (pend_q || (state_q == S_DRAIN));

    if (emit) begin
      j_d = j_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          num_vec_d  = num_vec;
          in_base_d  = in_base;
          w_base_d   = w_base;
          out_base_d = out_base;
          load_cnt_d = '0;
          k_d        = '0;
          j_d        = '0;
        end
      end
      S_LOAD: begin
        in_rd_en   = 1'b1;
        load_cnt_d = load_cnt_q + LCW'(1);
        if (load_cnt_q == LCW'(ARRAY_WIDTH - 1)) begin
          state_d = (num_vec_q == '0) ? S_FIN : S_STREAM;
        end
      end
      S_STREAM: begin
        w_rd_en = !stall;
        if (!stall) begin
          k_d = k_q + CNT_WIDTH'(1);
          if (k_q == num_vec_q - CNT_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (emit && (j_q == num_vec_q - CNT_WIDTH'(1))) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pending weight: set by a read, cleared when the array takes it; SRAM
    // output holds while we wait, so nothing is lost across a stall.
    pend_d = w_rd_en || (pend_q && !process_en);

    if (process_en) begin
      vld_d = {vld_q[OUT_LATENCY-2:0], pend_q};
    end
  end

  // State and datapath registers; reset aborts any tile in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_vec_q  <= '0;
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_base_q <= '0;
      load_cnt_q <= '0;
      k_q        <= '0;
      j_q        <= '0;
      pend_q     <= 1'b0;
      vld_q      <= '0;
      input_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the
      // values from before this edge, regardless of statement order.
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      in_base_q  <= in_base_d;
      w_base_q   <= w_base_d;
      out_base_q <= out_base_d;
      load_cnt_q <= load_cnt_d;
      k_q        <= k_d;
      j_q        <= j_d;
      pend_q     <= pend_d;
      vld_q      <= vld_d;
      input_en_q <= in_rd_en;
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] busy_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign busy_cnt  = busy_cnt_q;

  // Saturating performance counters, cleared when a tile is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      if (stall && ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
          (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state_q != S_IDLE) && (busy_cnt_q != '1)) begin
        busy_cnt_q <= busy_cnt_q + 32'd1;
      end
    end
  end
`else
  // accept only feeds the performance counters.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_systolic_array_is_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_is_ctrl
// Table of tiles applied in a loop; per-tile scoreboards hold the expected
// input, weight and psum addresses, popped as the DUT produces them. Cycle
// windows and done timing come from the tile parameters. Hand-written
// sequences cover a mid-tile reset and a clean restart.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_systolic_array_is_ctrl;

  localparam int AW  = 16;
  localparam int AH  = 16;
  localparam int ADW = 10;
  localparam int CW  = 10;
  localparam int OL  = AW + AH;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [CW-1:0]  num_vec;
  logic [ADW-1:0] in_base, w_base, out_base;
  logic           ready, done;
  logic           in_rd_en, w_rd_en, input_en, process_en;
  logic [ADW-1:0] in_rd_addr, w_rd_addr, psum_wr_addr;
  logic           psum_ready, psum_valid;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]    stall_cnt, busy_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_array_is_ctrl #(
    .ARRAY_HEIGHT(AH),
    .ARRAY_WIDTH (AW),
    .ADDR_WIDTH  (ADW),
    .CNT_WIDTH   (CW),
    .OUT_LATENCY (OL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vec     (num_vec),
    .in_base     (in_base),
    .w_base      (w_base),
    .out_base    (out_base),
    .ready       (ready),
    .done        (done),
    .in_rd_en    (in_rd_en),
    .in_rd_addr  (in_rd_addr),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .input_en    (input_en),
    .process_en  (process_en),
    .psum_ready  (psum_ready),
    .psum_valid  (psum_valid),
    .psum_wr_addr(psum_wr_addr)
`ifdef SA_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .busy_cnt    (busy_cnt)
`endif
  );

  typedef struct {
    int unsigned    num_vec;
    logic [ADW-1:0] in_base;
    logic [ADW-1:0] w_base;
    logic [ADW-1:0] out_base;
    int             stall_at;   // index of the valid psum to refuse, -1 none
    int             stall_len;  // cycles psum_ready held low on it
    bit             idle_nr;    // psum_ready low whenever no psum is valid
    bit             poke;       // extra start while busy and while done=1
  } tile_t;

  tile_t tiles[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  task automatic run_tile(input tile_t t);
    logic [ADW-1:0] in_q[$];
    logic [ADW-1:0] w_q[$];
    logic [ADW-1:0] p_q[$];
    int d, emitted, stall_left, pe_cnt, exp_pe;
    logic pr;

    d = (t.num_vec == 0) ? AW + 1 : AW + int'(t.num_vec) + OL + 2 + t.stall_len;
    exp_pe = (t.num_vec == 0) ? 0 : int'(t.num_vec) + OL;
    for (int i = 0; i < AW; i++) in_q.push_back(t.in_base + ADW'(i));
    for (int i = 0; i < int'(t.num_vec); i++) begin
      w_q.push_back(t.w_base + ADW'(i));
      p_q.push_back(t.out_base + ADW'(i));
    end
    emitted    = 0;
    stall_left = t.stall_len;
    pe_cnt     = 0;

    @(posedge clk); #1;
    start      = 1'b1;
    num_vec    = CW'(t.num_vec);
    in_base    = t.in_base;
    w_base     = t.w_base;
    out_base   = t.out_base;
    psum_ready = 1'b1;
    @(negedge clk);
    check("ready_before_start", ready, 1'b1);

    for (int cyc = 1; cyc <= d; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (t.poke && (cyc == 5 || cyc == d)) begin
        start    = 1'b1;
        num_vec  = CW'(7);
        in_base  = '1;
        w_base   = '1;
        out_base = '1;
      end
      pr = 1'b1;
      if (t.idle_nr && !psum_valid) pr = 1'b0;
      if (psum_valid && emitted == t.stall_at && stall_left > 0) begin
        pr = 1'b0;
        stall_left--;
      end
      psum_ready = pr;

      @(negedge clk);
      check("ready_busy", ready, 1'b0);
      check("done", done, cyc == d);
      check("in_rd_en", in_rd_en, cyc <= AW);
      check("input_en", input_en, cyc >= 2 && cyc <= AW + 1);
      if (in_rd_en) begin
        if (in_q.size() == 0) flag("in_rd_extra");
        else check("in_rd_addr", in_rd_addr, in_q.pop_front());
      end
      if (cyc <= AW) check("w_rd_en_during_load", w_rd_en, 1'b0);
      if (cyc == AW + 1) check("first_w_rd_en", w_rd_en, t.num_vec > 0);
      if (w_rd_en) begin
        if (w_q.size() == 0) flag("w_rd_extra");
        else check("w_rd_addr", w_rd_addr, w_q.pop_front());
      end
      if (process_en) pe_cnt++;
      if (psum_valid && psum_ready) begin
        if (p_q.size() == 0) flag("psum_extra");
        else check("psum_wr_addr", psum_wr_addr, p_q.pop_front());
        emitted++;
      end else if (psum_valid) begin
        check("stall_process_en", process_en, 1'b0);
        check("stall_w_rd_en", w_rd_en, 1'b0);
        if (p_q.size() == 0) flag("stall_psum_extra");
        else check("stall_hold_addr", psum_wr_addr, p_q[0]);
      end
    end

    @(posedge clk); #1;
    start      = 1'b0;
    psum_ready = 1'b1;
    @(negedge clk);
    check("ready_after_done", ready, 1'b1);
    check("done_one_cycle", done, 1'b0);
    check("in_reads_left", in_q.size(), 0);
    check("w_reads_left", w_q.size(), 0);
    check("psum_writes_left", p_q.size(), 0);
    check("process_en_cycles", pe_cnt, exp_pe);
`ifdef SA_CTRL_PERF_EN
    check("busy_cnt", busy_cnt, d);
    check("stall_cnt", stall_cnt, t.stall_len);
`endif
    if (t.poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("poke_stays_idle", in_rd_en, 1'b0);
        check("poke_ready", ready, 1'b1);
      end
    end
  endtask

  initial begin
    // num_vec, in_base, w_base, out_base, stall_at, stall_len, idle_nr, poke
    tiles[0] = '{4,  10'h010, 10'h100, 10'h200, -1, 0, 1'b0, 1'b0};
    tiles[1] = '{0,  10'h030, 10'h000, 10'h000, -1, 0, 1'b0, 1'b0};
    tiles[2] = '{8,  10'h000, 10'h040, 10'h300,  2, 5, 1'b0, 1'b0};
    tiles[3] = '{4,  10'h3FC, 10'h3FE, 10'h3FE, -1, 0, 1'b0, 1'b0};
    tiles[4] = '{40, 10'h005, 10'h080, 10'h120,  0, 3, 1'b1, 1'b0};
    tiles[5] = '{2,  10'h011, 10'h022, 10'h033, -1, 0, 1'b0, 1'b1};
    tiles[6] = '{1,  10'h0AA, 10'h0BB, 10'h0CC, -1, 0, 1'b0, 1'b0};

    rst        = 1'b1;
    start      = 1'b0;
    num_vec    = '0;
    in_base    = '0;
    w_base     = '0;
    out_base   = '0;
    psum_ready = 1'b1;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_in_rd_en", in_rd_en, 1'b0);
    check("rst_w_rd_en", w_rd_en, 1'b0);
    check("rst_input_en", input_en, 1'b0);
    check("rst_process_en", process_en, 1'b0);
    check("rst_psum_valid", psum_valid, 1'b0);
    check("rst_in_rd_addr", in_rd_addr, '0);
    check("rst_w_rd_addr", w_rd_addr, '0);
    check("rst_psum_wr_addr", psum_wr_addr, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tiles[i]) run_tile(tiles[i]);

    // Reset in the middle of streaming: everything drops at once, no done.
    @(posedge clk); #1;
    start    = 1'b1;
    num_vec  = CW'(8);
    in_base  = 10'h001;
    w_base   = 10'h002;
    out_base = 10'h003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid_stream_w_rd_en", w_rd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_w_rd_en", w_rd_en, 1'b0);
    check("abort_process_en", process_en, 1'b0);
    check("abort_in_rd_en", in_rd_en, 1'b0);
    check("abort_input_en", input_en, 1'b0);
    check("abort_psum_valid", psum_valid, 1'b0);
    check("abort_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end

    // A full clean tile after the abort.
    run_tile(tiles[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
